// File: rtl/wavetable_rd_arbiter_if.sv
// Bus bundle for the wavetable read-port arbiter: oscillator request path,
// host readback path and the shared RAM read port.
interface wavetable_rd_arbiter_if #(
    parameter int ADDRWIDTH = 8,
    parameter int DATAWIDTH = 16,
    parameter int BANKWIDTH = 2
);
    logic                 osc_req;
    logic [ADDRWIDTH-1:0] osc_addr;
    logic [BANKWIDTH-1:0] osc_bank;
    logic                 osc_valid;
    logic [DATAWIDTH-1:0] osc_data;
    logic                 osc_drop;
    logic                 ext_enable;
    logic                 ext_read;
    logic [BANKWIDTH-1:0] ext_bank;
    logic                 ext_valid;
    logic [DATAWIDTH-1:0] ext_data;
    logic [ADDRWIDTH-1:0] ext_addr;
    logic [ADDRWIDTH-1:0] RADDR;
    logic [BANKWIDTH-1:0] rbank;
    logic                 RCLK;
    logic [DATAWIDTH-1:0] RDATA;
    logic                 busy;

    modport slave (
        input  osc_req, osc_addr, osc_bank, ext_enable, ext_read, ext_bank, RDATA,
        output osc_valid, osc_data, osc_drop, ext_valid, ext_data, ext_addr,
               RADDR, rbank, RCLK, busy
    );

    modport master (
        output osc_req, osc_addr, osc_bank, ext_enable, ext_read, ext_bank, RDATA,
        input  osc_valid, osc_data, osc_drop, ext_valid, ext_data, ext_addr,
               RADDR, rbank, RCLK, busy
    );
endinterface

// File: rtl/wavetable_rd_arbiter.sv
// Shares the single wavetable RAM read port between the oscillator (priority)
// and the host readback path, with a starvation limit guaranteeing host progress.
module wavetable_rd_arbiter #(
    parameter int ADDRWIDTH      = 8,
    parameter int DATAWIDTH      = 16,
    parameter int BANKWIDTH      = 2,
    parameter int EXT_STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    wavetable_rd_arbiter_if.slave bus
);
    localparam int SW = $clog2(EXT_STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(EXT_STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_osc_pend;
    logic [ADDRWIDTH-1:0] r_osc_addr;
    logic [BANKWIDTH-1:0] r_osc_bank;
    logic                 r_osc_drop;
    logic                 r_osc_valid;
    logic [DATAWIDTH-1:0] r_osc_data;
    logic                 r_ext_pend;
    logic                 r_ext_prev;
    logic                 r_ext_kill;
    logic [ADDRWIDTH-1:0] r_ext_addr;
    logic                 r_ext_valid;
    logic [DATAWIDTH-1:0] r_ext_data;
    logic [SW-1:0]        r_starve;
    logic                 r_owner_ext;
    logic [ADDRWIDTH-1:0] r_raddr;
    logic [BANKWIDTH-1:0] r_rbank;
    logic                 r_rclk;
    logic                 r_busy;

    logic w_idle;
    logic w_sel_ext;
    logic w_sel_osc;
    logic w_gnt_osc;
    logic w_gnt_ext;
    logic w_ext_edge;

    // Host wins a contested slot only once the oscillator has used up its allowance.
    assign w_idle     = (r_state == S_IDLE);
    assign w_sel_ext  = r_ext_pend && (!r_osc_pend || (r_starve == STARVE_MAX));
    assign w_sel_osc  = r_osc_pend && !w_sel_ext;
    assign w_gnt_osc  = w_idle && w_sel_osc;
    assign w_gnt_ext  = w_idle && w_sel_ext;
    assign w_ext_edge = bus.ext_read && !r_ext_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_osc_pend  <= 1'b0;
            r_osc_addr  <= '0;
            r_osc_bank  <= '0;
            r_osc_drop  <= 1'b0;
            r_osc_valid <= 1'b0;
            r_osc_data  <= '0;
            r_ext_pend  <= 1'b0;
            r_ext_prev  <= 1'b0;
            r_ext_kill  <= 1'b0;
            r_ext_addr  <= '0;
            r_ext_valid <= 1'b0;
            r_ext_data  <= '0;
            r_starve    <= '0;
            r_owner_ext <= 1'b0;
            r_raddr     <= '0;
            r_rbank     <= '0;
            r_rclk      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_osc_valid <= 1'b0;
            r_ext_valid <= 1'b0;
            r_osc_drop  <= 1'b0;
            r_ext_prev  <= bus.ext_read;

            // A fresh request landing on the grant cycle re-arms the pend flag.
            if (w_gnt_osc)
                r_osc_pend <= 1'b0;
            if (bus.osc_req) begin
                r_osc_pend <= 1'b1;
                r_osc_addr <= bus.osc_addr;
                r_osc_bank <= bus.osc_bank;
                if (r_osc_pend && !w_gnt_osc)
                    r_osc_drop <= 1'b1;
            end

            if (!bus.ext_enable)
                r_ext_pend <= 1'b0;
            else if (w_ext_edge)
                r_ext_pend <= 1'b1;
            else if (w_gnt_ext)
                r_ext_pend <= 1'b0;

            // Kill marks an ext access whose result must be discarded.
            if (!bus.ext_enable)
                r_ext_kill <= 1'b1;
            else if (w_gnt_ext)
                r_ext_kill <= 1'b0;

            if (w_gnt_ext || !r_ext_pend)
                r_starve <= '0;
            else if (w_gnt_osc && (r_starve != STARVE_MAX))
                r_starve <= r_starve + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_sel_ext || w_sel_osc) begin
                        r_owner_ext <= w_sel_ext;
                        r_raddr     <= w_sel_ext ? r_ext_addr : r_osc_addr;
                        r_rbank     <= w_sel_ext ? bus.ext_bank : r_osc_bank;
                        r_rclk      <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_rclk  <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (!r_owner_ext) begin
                        r_osc_data  <= bus.RDATA;
                        r_osc_valid <= 1'b1;
                    end else if (bus.ext_enable && !r_ext_kill) begin
                        r_ext_data  <= bus.RDATA;
                        r_ext_valid <= 1'b1;
                        r_ext_addr  <= r_ext_addr + 1'b1;
                    end
                end
                default: begin
                    r_rclk  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase

            if (!bus.ext_enable)
                r_ext_addr <= '0;
        end
    end

    assign bus.osc_valid = r_osc_valid;
    assign bus.osc_data  = r_osc_data;
    assign bus.osc_drop  = r_osc_drop;
    assign bus.ext_valid = r_ext_valid;
    assign bus.ext_data  = r_ext_data;
    assign bus.ext_addr  = r_ext_addr;
    assign bus.RADDR     = r_raddr;
    assign bus.rbank     = r_rbank;
    assign bus.RCLK      = r_rclk;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_wavetable_rd_arbiter.sv
// Scoreboard bench for wavetable_rd_arbiter: directed stimulus pushes expected
// RAM accesses and completions; a negedge monitor pops and compares them.
module tb_wavetable_rd_arbiter;
    logic clk;
    logic rst;

    wavetable_rd_arbiter_if #(.ADDRWIDTH(8), .DATAWIDTH(16), .BANKWIDTH(2)) bus ();

    wavetable_rd_arbiter #(
        .ADDRWIDTH(8), .DATAWIDTH(16), .BANKWIDTH(2), .EXT_STARVE_MAX(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: data = {6'b0, bank, addr}, one cycle after RCLK.
    always @(posedge clk) begin
        if (bus.RCLK)
            bus.RDATA <= {6'b0, bus.rbank, bus.RADDR};
    end

    int total = 0;
    int bad   = 0;
    int n_osc = 0;
    int n_ext = 0;
    int n_drop = 0;
    logic prev_rclk = 1'b0;

    logic [9:0]  acc_q[$];
    logic [15:0] osc_q[$];
    logic [23:0] ext_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.RCLK) begin
            if (prev_rclk) chk("rclk_one_cycle", 32'd1, 32'd0);
            if (acc_q.size() == 0) begin
                chk("acc_unexpected", {22'b0, bus.rbank, bus.RADDR}, 32'hFFFFFFFF);
            end else begin
                logic [9:0] e;
                e = acc_q.pop_front();
                $display("access bank=%0d addr=%02h", bus.rbank, bus.RADDR);
                chk("acc", {22'b0, bus.rbank, bus.RADDR}, {22'b0, e});
            end
        end
        prev_rclk = bus.RCLK;
        if (bus.osc_valid) begin
            n_osc++;
            if (osc_q.size() == 0) begin
                chk("osc_unexpected", {16'b0, bus.osc_data}, 32'hFFFFFFFF);
            end else begin
                logic [15:0] e;
                e = osc_q.pop_front();
                $display("osc done data=%04h", bus.osc_data);
                chk("osc_data", {16'b0, bus.osc_data}, {16'b0, e});
            end
        end
        if (bus.ext_valid) begin
            n_ext++;
            if (ext_q.size() == 0) begin
                chk("ext_unexpected", {8'b0, bus.ext_data, bus.ext_addr}, 32'hFFFFFFFF);
            end else begin
                logic [23:0] e;
                e = ext_q.pop_front();
                $display("ext done data=%04h next_addr=%02h", bus.ext_data, bus.ext_addr);
                chk("ext_data_addr", {8'b0, bus.ext_data, bus.ext_addr}, {8'b0, e});
            end
        end
        if (bus.osc_drop) n_drop++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ext(input int target);
        int b = 0;
        while (n_ext < target && b < 200) begin
            tick();
            b++;
        end
        chk("ext_count", n_ext, target);
    endtask

    task automatic wait_osc(input int target);
        int b = 0;
        while (n_osc < target && b < 200) begin
            tick();
            b++;
        end
        chk("osc_count", n_osc, target);
    endtask

    task automatic ext_strobe();
        bus.ext_read = 1'b0;
        tick();
        bus.ext_read = 1'b1;
        tick();
    endtask

    initial begin
        int drops0;
        rst = 1'b1;
        bus.osc_req = 1'b0; bus.osc_addr = '0; bus.osc_bank = '0;
        bus.ext_enable = 1'b0; bus.ext_read = 1'b0; bus.ext_bank = '0;
        bus.RDATA = '0;
        repeat (3) tick();
        chk("rst_raddr", bus.RADDR, 0);
        chk("rst_rbank", bus.rbank, 0);
        chk("rst_rclk", bus.RCLK, 0);
        chk("rst_valids", {bus.osc_valid, bus.ext_valid, bus.osc_drop}, 0);
        chk("rst_data", {bus.osc_data, bus.ext_data}, 0);
        chk("rst_ext_addr", bus.ext_addr, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        bus.ext_enable = 1'b1;
        tick();

        // 1: first ext read, latency check
        acc_q.push_back({2'd0, 8'h00});
        ext_q.push_back({16'h0000, 8'h01});
        bus.ext_read = 1'b1;
        tick();
        tick();
        chk("t1_rclk_hi", bus.RCLK, 1);
        chk("t1_busy", bus.busy, 1);
        tick();
        chk("t1_rclk_lo", bus.RCLK, 0);
        tick();
        chk("t1_ext_valid", bus.ext_valid, 1);
        wait_ext(1);

        // 2: second ext read after a long low
        acc_q.push_back({2'd0, 8'h01});
        ext_q.push_back({16'h0001, 8'h02});
        bus.ext_read = 1'b0;
        repeat (4) tick();
        bus.ext_read = 1'b1;
        tick();
        wait_ext(2);
        chk("t2_no_osc", n_osc, 0);
        tick();

        // 3: simultaneous osc and ext -> osc first
        acc_q.push_back({2'd2, 8'h40});
        acc_q.push_back({2'd3, 8'h02});
        osc_q.push_back(16'h0240);
        ext_q.push_back({16'h0302, 8'h03});
        bus.ext_read = 1'b0;
        bus.ext_bank = 2'd3;
        tick();
        bus.osc_req = 1'b1; bus.osc_addr = 8'h40; bus.osc_bank = 2'd2;
        bus.ext_read = 1'b1;
        tick();
        bus.osc_req = 1'b0;
        wait_osc(1);
        wait_ext(3);
        bus.ext_bank = 2'd0;
        tick();

        // 4: continuous osc traffic, ext forced after 4 osc grants
        drops0 = n_drop;
        for (int i = 0; i < 4; i++) acc_q.push_back({2'd1, 8'h50 + 8'(i)});
        acc_q.push_back({2'd0, 8'h03});
        acc_q.push_back({2'd1, 8'h54});
        for (int i = 0; i < 5; i++) osc_q.push_back(16'h0150 + 16'(i));
        ext_q.push_back({16'h0003, 8'h04});
        bus.ext_read = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.osc_req = 1'b1; bus.osc_addr = 8'h50 + 8'(i); bus.osc_bank = 2'd1;
            if (i == 0) bus.ext_read = 1'b1;
            tick();
            bus.osc_req = 1'b0;
            tick();
            tick();
        end
        wait_osc(6);
        wait_ext(4);
        chk("t4_no_drop", n_drop - drops0, 0);
        tick();

        // 5: two osc requests while busy -> one drop, access at 8'h20
        drops0 = n_drop;
        acc_q.push_back({2'd0, 8'h04});
        ext_q.push_back({16'h0004, 8'h05});
        acc_q.push_back({2'd3, 8'h20});
        osc_q.push_back(16'h0320);
        ext_strobe();
        bus.osc_req = 1'b1; bus.osc_addr = 8'h10; bus.osc_bank = 2'd3;
        tick();
        bus.osc_addr = 8'h20;
        tick();
        bus.osc_req = 1'b0;
        wait_ext(5);
        wait_osc(7);
        chk("t5_one_drop", n_drop - drops0, 1);
        tick();

        // 6: walk ext pointer to 8'hFF and wrap
        for (int a = 5; a < 256; a++) begin
            acc_q.push_back({2'd0, 8'(a)});
            ext_q.push_back({8'h00, 8'(a), 8'(a + 1)});
            ext_strobe();
            wait_ext(a + 1);
        end
        chk("t6_wrap", bus.ext_addr, 0);
        acc_q.push_back({2'd0, 8'h00});
        ext_q.push_back({16'h0000, 8'h01});
        ext_strobe();
        wait_ext(257);
        chk("t6_addr1", bus.ext_addr, 1);

        // enable drop during WAIT: access completes, result discarded
        acc_q.push_back({2'd0, 8'h01});
        ext_strobe();
        tick();
        tick();
        bus.ext_enable = 1'b0;
        repeat (4) tick();
        chk("t6_kill_no_valid", n_ext, 257);
        chk("t6_kill_addr", bus.ext_addr, 0);
        chk("t6_kill_data", bus.ext_data, 16'h0000);

        // reset while in ISSUE
        bus.ext_enable = 1'b1;
        acc_q.push_back({2'd0, 8'h00});
        ext_strobe();
        tick();
        chk("t6_issue_rclk", bus.RCLK, 1);
        rst = 1'b1;
        bus.ext_read = 1'b0;
        tick();
        chk("t6_rst_rclk", bus.RCLK, 0);
        chk("t6_rst_busy", bus.busy, 0);
        rst = 1'b0;
        repeat (6) tick();
        chk("t6_rst_no_ext", n_ext, 257);
        chk("t6_rst_no_osc", n_osc, 7);
        chk("t6_rst_osc_data", bus.osc_data, 0);
        chk("t6_rst_busy_after", bus.busy, 0);

        chk("acc_q_empty", acc_q.size(), 0);
        chk("osc_q_empty", osc_q.size(), 0);
        chk("ext_q_empty", ext_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
